// File: rtl/debug_mem_master_if.sv
// Host command/write/read channels plus instruction- and data-cache debug ports
// of the debug memory master, bundled for one connection point.
interface debug_mem_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;

    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;
    logic [3:0]  wdata_be;

    logic        rdata_valid;
    logic        rdata_ready;
    logic [31:0] rdata;
    logic        rdata_last;

    logic        busy;
    logic        done;

    logic [31:0] CPU_Debug_InstCache_A2;
    logic [31:0] CPU_Debug_InstCache_WD2;
    logic [3:0]  CPU_Debug_InstCache_WE2;
    logic [31:0] CPU_Debug_InstCache_RD2;

    logic [31:0] CPU_Debug_DataCache_A2;
    logic [31:0] CPU_Debug_DataCache_WD2;
    logic [3:0]  CPU_Debug_DataCache_WE2;
    logic [31:0] CPU_Debug_DataCache_RD2;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len,
        input  wdata_valid, wdata, wdata_be,
        input  rdata_ready,
        input  CPU_Debug_InstCache_RD2, CPU_Debug_DataCache_RD2,
        output cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, busy, done,
        output CPU_Debug_InstCache_A2, CPU_Debug_InstCache_WD2, CPU_Debug_InstCache_WE2,
        output CPU_Debug_DataCache_A2, CPU_Debug_DataCache_WD2, CPU_Debug_DataCache_WE2
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_len,
        output wdata_valid, wdata, wdata_be,
        output rdata_ready,
        output CPU_Debug_InstCache_RD2, CPU_Debug_DataCache_RD2,
        input  cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, busy, done,
        input  CPU_Debug_InstCache_A2, CPU_Debug_InstCache_WD2, CPU_Debug_InstCache_WE2,
        input  CPU_Debug_DataCache_A2, CPU_Debug_DataCache_WD2, CPU_Debug_DataCache_WE2
    );
endinterface

// File: rtl/debug_mem_master.sv
// Debug-side burst initiator: turns host word-burst commands into single-cycle
// address/data/byte-enable cycles on the instruction or data cache debug port.
module debug_mem_master #(
    parameter int unsigned READ_LATENCY = 1
) (
    input logic                CPU_CLK,
    input logic                CPU_RST_N,
    debug_mem_master_if.master bus
);

    localparam logic [2:0] LatLast = 3'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle, StWrite, StRdIssue, StRdWait, StRdHold, StDone
    } state_e;

    state_e      state_q, state_d;
    logic        sel_data_q, sel_data_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  lat_q, lat_d;
    logic [31:0] inst_a2_q, inst_a2_d, inst_wd2_q, inst_wd2_d;
    logic [3:0]  inst_we2_q, inst_we2_d;
    logic [31:0] data_a2_q, data_a2_d, data_wd2_q, data_wd2_d;
    logic [3:0]  data_we2_q, data_we2_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic        rdata_last_q, rdata_last_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        a2_load;
    logic [31:0] a2_val;
    logic        wr_fire;
    logic        sel_data;

    always_comb begin
        state_d       = state_q;
        sel_data_d    = sel_data_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        lat_d         = lat_q;
        inst_a2_d     = inst_a2_q;
        inst_wd2_d    = inst_wd2_q;
        inst_we2_d    = 4'b0000;
        data_a2_d     = data_a2_q;
        data_wd2_d    = data_wd2_q;
        data_we2_d    = 4'b0000;
        rdata_d       = rdata_q;
        rdata_valid_d = rdata_valid_q;
        rdata_last_d  = rdata_last_q;
        done_d        = 1'b0;
        a2_load       = 1'b0;
        a2_val        = addr_q;
        wr_fire       = 1'b0;
        sel_data      = sel_data_q;

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    sel_data_d = bus.cmd_op[0];
                    sel_data   = bus.cmd_op[0];
                    addr_d     = bus.cmd_addr & 32'hFFFF_FFFC;
                    cnt_d      = bus.cmd_len;
                    if (bus.cmd_op[1]) begin
                        a2_load = 1'b1;
                        a2_val  = addr_d;
                        state_d = StRdIssue;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                if (bus.wdata_valid) begin
                    wr_fire = 1'b1;
                    a2_load = 1'b1;
                    addr_d  = addr_q + 32'd4;
                    cnt_d   = cnt_q - 8'd1;
                    if (cnt_q == 8'd0) state_d = StDone;
                end
            end
            StRdIssue: begin
                lat_d   = 3'd0;
                state_d = StRdWait;
            end
            StRdWait: begin
                if (lat_q == LatLast) begin
                    rdata_d       = sel_data_q ? bus.CPU_Debug_DataCache_RD2
                                               : bus.CPU_Debug_InstCache_RD2;
                    rdata_valid_d = 1'b1;
                    rdata_last_d  = (cnt_q == 8'd0);
                    state_d       = StRdHold;
                end else begin
                    lat_d = lat_q + 3'd1;
                end
            end
            StRdHold: begin
                if (bus.rdata_ready) begin
                    rdata_valid_d = 1'b0;
                    rdata_last_d  = 1'b0;
                    if (rdata_last_q) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + 32'd4;
                        cnt_d   = cnt_q - 8'd1;
                        a2_load = 1'b1;
                        a2_val  = addr_d;
                        state_d = StRdIssue;
                    end
                end
            end
            StDone: begin
                // A write lands here one cycle early so its last WE2 cycle precedes done.
                if (done_q) state_d = StIdle;
                else        done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (a2_load) begin
            if (sel_data) data_a2_d = a2_val;
            else          inst_a2_d = a2_val;
        end
        if (wr_fire) begin
            if (sel_data) begin
                data_wd2_d = bus.wdata;
                data_we2_d = bus.wdata_be;
            end else begin
                inst_wd2_d = bus.wdata;
                inst_we2_d = bus.wdata_be;
            end
        end
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            state_q       <= StIdle;
            sel_data_q    <= 1'b0;
            addr_q        <= 32'd0;
            cnt_q         <= 8'd0;
            lat_q         <= 3'd0;
            inst_a2_q     <= 32'd0;
            inst_wd2_q    <= 32'd0;
            inst_we2_q    <= 4'b0000;
            data_a2_q     <= 32'd0;
            data_wd2_q    <= 32'd0;
            data_we2_q    <= 4'b0000;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
            rdata_last_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_data_q    <= sel_data_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            lat_q         <= lat_d;
            inst_a2_q     <= inst_a2_d;
            inst_wd2_q    <= inst_wd2_d;
            inst_we2_q    <= inst_we2_d;
            data_a2_q     <= data_a2_d;
            data_wd2_q    <= data_wd2_d;
            data_we2_q    <= data_we2_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_last_q  <= rdata_last_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus.cmd_ready   = (state_q == StIdle) && CPU_RST_N;
    assign bus.wdata_ready = (state_q == StWrite);
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.rdata_last  = rdata_last_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

    assign bus.CPU_Debug_InstCache_A2  = inst_a2_q;
    assign bus.CPU_Debug_InstCache_WD2 = inst_wd2_q;
    assign bus.CPU_Debug_InstCache_WE2 = inst_we2_q;
    assign bus.CPU_Debug_DataCache_A2  = data_a2_q;
    assign bus.CPU_Debug_DataCache_WD2 = data_wd2_q;
    assign bus.CPU_Debug_DataCache_WE2 = data_we2_q;

endmodule
